// File: rtl/uio_bus_arbiter_if.sv
// Bundle of the uio arbiter's request/grant, data and pad signals.
// Requesters hold req (level) and own the pads while their gnt bit is high;
// a requester that drops req must also drive its wr_oe to 0 in that same cycle.
interface uio_bus_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = $clog2(N_REQ);

  logic                 ena;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     last;
  logic [8*N_REQ-1:0]   wr_data;
  logic [8*N_REQ-1:0]   wr_oe;
  logic [7:0]           uio_in;
  logic [N_REQ-1:0]     gnt;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic [7:0]           rd_data;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;

  modport slave (
    input  ena, req, last, wr_data, wr_oe, uio_in,
    output gnt, owner, busy, rd_data, uio_out, uio_oe
  );

  modport master (
    output ena, req, last, wr_data, wr_oe, uio_in,
    input  gnt, owner, busy, rd_data, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner selection for the shared uio pad bus, with bounded bursts
// and a tristated turnaround gap between owners.
module uio_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  uio_bus_arbiter_if.slave  bus,
  output logic [1:0]        o_dbg_state
);
  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [1:0]    TURN_LAST = 2'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t           r_state, w_next;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [BW-1:0]    r_beat, w_beat_nxt;
  logic [1:0]       r_turn, w_turn_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [7:0]       r_rd_data;

  logic             w_hi_vld, w_lo_vld, w_win_vld, w_arb;
  logic [OW-1:0]    w_hi, w_lo, w_win;
  logic             w_own_req, w_own_last, w_burst_end;
  logic [7:0]       w_own_data, w_own_oe;

  // Requests above the current owner beat requests at or below it; within
  // each half the lowest index wins, giving a rotating search from owner+1.
  always_comb begin
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (OW'(i) > r_owner)) begin
        w_hi_vld = 1'b1;
        w_hi     = OW'(i);
      end
      if (bus.req[i] && (OW'(i) <= r_owner)) begin
        w_lo_vld = 1'b1;
        w_lo     = OW'(i);
      end
    end
    w_win_vld = w_hi_vld | w_lo_vld;
    w_win     = w_hi_vld ? w_hi : w_lo;
    w_arb     = bus.ena & w_win_vld;
  end

  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    w_own_oe   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_own_req  = bus.req[i];
        w_own_last = bus.last[i];
        w_own_data = bus.wr_data[8*i +: 8];
        w_own_oe   = bus.wr_oe[8*i +: 8];
      end
    end
    w_burst_end = w_own_last | ~w_own_req | (r_beat == BEAT_LAST);
  end

  always_comb begin
    w_next      = r_state;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat;
    w_turn_nxt  = r_turn;
    case (r_state)
      S_IDLE: begin
        if (w_arb) begin
          w_next      = S_GRANT;
          w_owner_nxt = w_win;
          w_beat_nxt  = '0;
        end
      end
      S_GRANT: begin
        w_beat_nxt = r_beat + 1'b1;
        if (w_burst_end) begin
          w_next     = S_TURN;
          w_turn_nxt = '0;
        end
      end
      S_TURN: begin
        if (r_turn == TURN_LAST) begin
          if (w_arb) begin
            w_next      = S_GRANT;
            w_owner_nxt = w_win;
            w_beat_nxt  = '0;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_turn_nxt = r_turn + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_gnt_nxt = (w_next == S_GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_owner_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= OW'(N_REQ - 1);
      r_beat    <= '0;
      r_turn    <= '0;
      r_gnt     <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_next;
      r_owner   <= w_owner_nxt;
      r_beat    <= w_beat_nxt;
      r_turn    <= w_turn_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rd_data <= bus.uio_in;
    end
  end

  // Pads are gated by the registered state so they are quiet outside GRANT.
  assign bus.gnt     = r_gnt;
  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.rd_data = r_rd_data;
  assign bus.uio_out = (r_state == S_GRANT) ? w_own_data : 8'h00;
  assign bus.uio_oe  = (r_state == S_GRANT) ? w_own_oe   : 8'h00;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a burst-level model.
module tb_uio_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int TA = 1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  uio_bus_arbiter_if #(.N_REQ(N)) bus ();

  uio_bus_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bus either carries a burst (granted), is in a gap of 'gap' remaining
  // tristated cycles, or is free; arbitration happens when free or in the
  // last gap cycle.
  typedef struct {
    bit         granted;
    int         gap;
    int         owner;
    int         beats;
    logic [7:0] rd;
  } model_t;

  model_t m;
  bit     m_valid = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] rq, input int from);
    for (int k = 1; k <= N; k++) begin
      if (rq[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic model_t model_step(input model_t s, input logic r, input logic e,
                                        input logic [N-1:0] rq, input logic [N-1:0] lst,
                                        input logic [7:0] ui);
    model_t t = s;
    bit may_arb;
    int w;
    if (r) begin
      t.granted = 1'b0;
      t.gap     = 0;
      t.owner   = N - 1;
      t.beats   = 0;
      t.rd      = 8'h00;
      return t;
    end
    t.rd = ui;
    if (s.granted) begin
      t.beats = s.beats + 1;
      if (lst[s.owner] || !rq[s.owner] || t.beats == MB) begin
        t.granted = 1'b0;
        t.gap     = TA;
      end
    end else begin
      may_arb = (s.gap <= 1);
      if (s.gap > 0) t.gap = s.gap - 1;
      w = rr_pick(rq, s.owner);
      if (may_arb && e && w >= 0) begin
        t.granted = 1'b1;
        t.owner   = w;
        t.beats   = 0;
        t.gap     = 0;
      end
    end
    return t;
  endfunction

  always @(posedge clk) begin
    m       <= model_step(m, rst, bus.ena, bus.req, bus.last, bus.uio_in);
    if (rst) m_valid <= 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      logic [N-1:0] e_gnt;
      logic [7:0]   e_out, e_oe;
      logic [1:0]   e_st;
      e_gnt = m.granted ? (N'(1) << m.owner) : '0;
      e_out = m.granted ? bus.wr_data[m.owner*8 +: 8] : 8'h00;
      e_oe  = m.granted ? bus.wr_oe[m.owner*8 +: 8]   : 8'h00;
      e_st  = m.granted ? 2'd1 : ((m.gap > 0) ? 2'd2 : 2'd0);
      check("model_gnt",     32'(bus.gnt),     32'(e_gnt));
      check("model_owner",   32'(bus.owner),   32'(m.owner));
      check("model_busy",    32'(bus.busy),    32'(m.granted || m.gap > 0));
      check("model_uio_out", 32'(bus.uio_out), 32'(e_out));
      check("model_uio_oe",  32'(bus.uio_oe),  32'(e_oe));
      check("model_rd_data", 32'(bus.rd_data), 32'(m.rd));
      check("model_state",   32'(dbg_state),   32'(e_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.req  = '0;
    bus.last = '0;
    while (bus.busy && n < 50) begin
      step();
      n++;
    end
    check("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  // Waits for a grant, then measures its length and the tristated gap after it.
  task automatic measure(output logic [N-1:0] g, output int run, output int gap);
    int n = 0;
    while (bus.gnt == '0 && n < 50) begin
      step();
      n++;
    end
    g   = bus.gnt;
    run = 0;
    gap = 0;
    while (g != '0 && bus.gnt == g && run < 300) begin
      run++;
      step();
    end
    while (bus.gnt == '0 && bus.uio_oe == 8'h00 && gap < 20) begin
      gap++;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] g;
    int           run, gap, cnt;
    logic [N-1:0] exp_q[$];

    rst         = 1'b1;
    bus.ena     = 1'b1;
    bus.req     = '0;
    bus.last    = '0;
    bus.wr_data = '0;
    bus.wr_oe   = '0;
    bus.uio_in  = 8'h3C;
    step();
    step();
    check("reset_gnt",   32'(bus.gnt),     32'h0);
    check("reset_owner", 32'(bus.owner),   32'd3);
    check("reset_busy",  32'(bus.busy),    32'd0);
    check("reset_rd",    32'(bus.rd_data), 32'h0);
    rst = 1'b0;
    step();
    check("rd_latency", 32'(bus.rd_data), 32'h3C);

    // Round-robin fairness from reset
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      measure(g, run, gap);
      check("rr_order", 32'(g), 32'(exp_q.pop_front()));
      check("rr_run", 32'(run), 32'd1);
      if (i < 4) check("rr_gap", 32'(gap), 32'd1);
    end
    wait_idle();

    // Single burst ended by last on beat 3
    bus.req     = 4'b0010;
    bus.wr_data = 32'h0000_A500;
    bus.wr_oe   = 32'h0000_FF00;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.gnt == 4'b0010) begin
        cnt++;
        check("single_out", 32'(bus.uio_out), 32'hA5);
        check("single_oe",  32'(bus.uio_oe),  32'hFF);
        if (cnt == 3) bus.last = 4'b0010;
      end else if (cnt > 0) begin
        break;
      end
    end
    bus.last = '0;
    check("single_len",  32'(cnt), 32'd3);
    check("single_turn_oe", 32'(bus.uio_oe), 32'h0);
    check("single_turn_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    wait_idle();

    // MAX_BURST cap with a single continuous requester
    bus.req = 4'b0001;
    measure(g, run, gap);
    check("cap_gnt", 32'(g), 32'h1);
    check("cap_run", 32'(run), 32'd8);
    check("cap_gap", 32'(gap), 32'd1);
    check("cap_regrant", 32'(bus.gnt), 32'h1);
    wait_idle();

    // Reset in the middle of a burst
    bus.req = 4'b0001;
    cnt = 0;
    while (bus.gnt == '0 && cnt < 20) begin
      step();
      cnt++;
    end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_gnt",   32'(bus.gnt),    32'h0);
    check("rst_mid_oe",    32'(bus.uio_oe), 32'h0);
    check("rst_mid_busy",  32'(bus.busy),   32'd0);
    check("rst_mid_owner", 32'(bus.owner),  32'd3);
    step();
    check("rst_regrant", 32'(bus.gnt), 32'h1);
    wait_idle();

    // ena gating in IDLE, then ena dropped mid-burst
    bus.ena = 1'b0;
    bus.req = 4'b0100;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.gnt != '0 || bus.busy) cnt++;
    end
    check("ena_blocked", 32'(cnt), 32'd0);
    bus.ena = 1'b1;
    step();
    check("ena_latency", 32'(bus.gnt), 32'h4);
    bus.ena = 1'b0;
    cnt = 0;
    while (bus.gnt == 4'b0100 && cnt < 20) begin
      cnt++;
      step();
    end
    check("ena_burst_len", 32'(cnt), 32'd8);
    step();
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.gnt != '0 || bus.busy) cnt++;
    end
    check("ena_no_regrant", 32'(cnt), 32'd0);

    // req drop on beat 2, requester 3 waiting
    bus.ena   = 1'b1;
    bus.wr_oe = 32'hFFFF_FFFF;
    cnt = 0;
    while (bus.gnt != 4'b0100 && cnt < 20) begin
      step();
      cnt++;
    end
    bus.req = 4'b1100;
    step();
    check("drop_beat2_gnt", 32'(bus.gnt), 32'h4);
    bus.req   = 4'b1000;
    bus.wr_oe = 32'hFF00_FFFF;
    step();
    check("drop_turn_gnt", 32'(bus.gnt),    32'h0);
    check("drop_turn_oe",  32'(bus.uio_oe), 32'h0);
    step();
    check("drop_next_gnt", 32'(bus.gnt), 32'h8);
    wait_idle();

    // Randomized traffic, checked by the model on every cycle
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      bus.ena     = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
        bus.last[i] = ($urandom_range(0, 3) == 0);
      end
      bus.wr_data = $urandom;
      bus.wr_oe   = $urandom;
      bus.uio_in  = 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
